// File: rtl/cp_wb_writer_if.sv
// Register-file writeback bundle for cp_wb_writer: EX/WB result, long-latency
// handshake, RF write port and status. CP_WB_PENDING_EN adds oWB_Pending_Mask.
interface cp_wb_writer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_INDEX_WIDTH = 5,
  parameter int LQ_DEPTH       = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic                      iEX_WB_Write_Enable;
  logic [RF_INDEX_WIDTH-1:0] iEX_WB_Write_Addr;
  logic [DATA_WIDTH-1:0]     iEX_WB_Write_Data;
  logic                      iLL_WB_Valid;
  logic [RF_INDEX_WIDTH-1:0] iLL_WB_Addr;
  logic [DATA_WIDTH-1:0]     iLL_WB_Data;
  logic                      oLL_WB_Ready;
  logic                      oWB_RF_Write_Enable;
  logic [RF_INDEX_WIDTH-1:0] oWB_RF_Write_Addr;
  logic [DATA_WIDTH-1:0]     oWB_RF_Write_Data;
  logic                      oWB_Stall_Req;
  logic [CNT_W-1:0]          oLQ_Count;
`ifdef CP_WB_PENDING_EN
  logic [(2**RF_INDEX_WIDTH)-1:0] oWB_Pending_Mask;
`endif

  modport master (
    output iEX_WB_Write_Enable, iEX_WB_Write_Addr, iEX_WB_Write_Data,
    output iLL_WB_Valid, iLL_WB_Addr, iLL_WB_Data,
    input  oLL_WB_Ready, oWB_RF_Write_Enable, oWB_RF_Write_Addr, oWB_RF_Write_Data,
    input  oWB_Stall_Req, oLQ_Count
`ifdef CP_WB_PENDING_EN
    , input oWB_Pending_Mask
`endif
  );

  modport slave (
    input  iEX_WB_Write_Enable, iEX_WB_Write_Addr, iEX_WB_Write_Data,
    input  iLL_WB_Valid, iLL_WB_Addr, iLL_WB_Data,
    output oLL_WB_Ready, oWB_RF_Write_Enable, oWB_RF_Write_Addr, oWB_RF_Write_Data,
    output oWB_Stall_Req, oLQ_Count
`ifdef CP_WB_PENDING_EN
    , output oWB_Pending_Mask
`endif
  );
endinterface

// File: rtl/cp_wb_writer.sv
// CP writeback merger: fixed-priority EX/WB writes plus a FIFO of long-latency
// results onto one RF write port. Optional CP_WB_PENDING_EN adds a pending-register mask.
module cp_wb_writer #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_INDEX_WIDTH = 5,
  parameter int LQ_DEPTH       = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input logic           iClk,
  input logic           iRst,
  cp_wb_writer_if.slave bus
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);
  localparam logic [ST_W-1:0]  LIMIT_C = ST_W'(STARVE_LIMIT);

  logic [RF_INDEX_WIDTH-1:0] r_lq_addr [LQ_DEPTH];
  logic [DATA_WIDTH-1:0]     r_lq_data [LQ_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [ST_W-1:0]           r_starve;
  logic                      r_stall;
  logic                      r_we;
  logic [RF_INDEX_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_data;

  logic                      w_exwr, w_empty, w_ready, w_xfer_nz;
  logic                      w_push, w_pop, w_sel_we;
  logic [RF_INDEX_WIDTH-1:0] w_sel_addr, w_head_addr;
  logic [DATA_WIDTH-1:0]     w_sel_data;
  logic [CNT_W-1:0]          w_count_next;
  logic [ST_W-1:0]           w_starve_next;

  assign w_exwr      = bus.iEX_WB_Write_Enable && (bus.iEX_WB_Write_Addr != {RF_INDEX_WIDTH{1'b0}});
  assign w_empty     = (r_count == {CNT_W{1'b0}});
  assign w_ready     = (r_count < DEPTH_C);
  assign w_xfer_nz   = bus.iLL_WB_Valid && w_ready && (bus.iLL_WB_Addr != {RF_INDEX_WIDTH{1'b0}});
  assign w_head_addr = r_lq_addr[r_rd_ptr];

  // Port arbitration: EX first, then queue head, then direct fall-through.
  always_comb begin
    w_pop      = 1'b0;
    w_push     = 1'b0;
    w_sel_we   = 1'b0;
    w_sel_addr = r_addr;
    w_sel_data = r_data;
    if (w_exwr) begin
      w_sel_we   = 1'b1;
      w_sel_addr = bus.iEX_WB_Write_Addr;
      w_sel_data = bus.iEX_WB_Write_Data;
      w_push     = w_xfer_nz;
    end else if (!w_empty) begin
      w_pop      = 1'b1;
      w_sel_we   = 1'b1;
      w_sel_addr = w_head_addr;
      w_sel_data = r_lq_data[r_rd_ptr];
      w_push     = w_xfer_nz;
    end else if (w_xfer_nz) begin
      w_sel_we   = 1'b1;
      w_sel_addr = bus.iLL_WB_Addr;
      w_sel_data = bus.iLL_WB_Data;
    end else begin
      w_sel_we   = 1'b0;
    end
  end

  // Next occupancy from push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Starvation counter: counts blocked-head cycles, saturating.
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || (w_count_next == {CNT_W{1'b0}})) begin
      w_starve_next = {ST_W{1'b0}};
    end else if (w_exwr && !w_empty) begin
      w_starve_next = (r_starve < LIMIT_C) ? (r_starve + ST_W'(1)) : r_starve;
    end else begin
      w_starve_next = r_starve;
    end
  end

  // Queue storage; contents need no reset since pointers and count gate them.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_lq_addr[r_wr_ptr] <= bus.iLL_WB_Addr;
      r_lq_data[r_wr_ptr] <= bus.iLL_WB_Data;
    end
  end

  // Control state and registered RF port.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_starve <= {ST_W{1'b0}};
      r_stall  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= {RF_INDEX_WIDTH{1'b0}};
      r_data   <= {DATA_WIDTH{1'b0}};
    end else begin
      r_we     <= w_sel_we;
      r_addr   <= w_sel_addr;
      r_data   <= w_sel_data;
      r_count  <= w_count_next;
      r_starve <= w_starve_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Stall drops only once an empty queue has been observed for a full cycle.
      if ((w_starve_next == LIMIT_C) || (w_count_next == DEPTH_C)) begin
        r_stall <= 1'b1;
      end else if (w_empty) begin
        r_stall <= 1'b0;
      end
    end
  end

  assign bus.oLL_WB_Ready        = w_ready;
  assign bus.oWB_RF_Write_Enable = r_we;
  assign bus.oWB_RF_Write_Addr   = r_addr;
  assign bus.oWB_RF_Write_Data   = r_data;
  assign bus.oWB_Stall_Req       = r_stall;
  assign bus.oLQ_Count           = r_count;

`ifdef CP_WB_PENDING_EN
  localparam int NREG = 2 ** RF_INDEX_WIDTH;

  logic [CNT_W-1:0] r_pend_cnt [NREG];
  logic [CNT_W-1:0] w_pend_next [NREG];
  logic [NREG-1:0]  r_pend_mask;

  // Per-register occupancy so duplicate destinations clear only on the last pop.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_pend_next[r] = r_pend_cnt[r]
                     + CNT_W'(w_push && (bus.iLL_WB_Addr == RF_INDEX_WIDTH'(r)))
                     - CNT_W'(w_pop && (w_head_addr == RF_INDEX_WIDTH'(r)));
    end
  end

  // Pending counts and mask track push/pop on the same edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int r = 0; r < NREG; r++) r_pend_cnt[r] <= {CNT_W{1'b0}};
      r_pend_mask <= {NREG{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) r_pend_cnt[r] <= w_pend_next[r];
      r_pend_mask[0] <= 1'b0;
      for (int r = 1; r < NREG; r++) r_pend_mask[r] <= (w_pend_next[r] != {CNT_W{1'b0}});
    end
  end

  assign bus.oWB_Pending_Mask = r_pend_mask;
`endif
endmodule

// File: doc/cp_wb_writer.md
Name: cp_wb_writer

Overview:
- CP writeback-side producer for the CP register file write port (write address, write data, write enable).
- Merges two sources onto that single port:
  - the in-order EX/WB result, which has fixed priority and is never stalled;
  - long-latency results (load return, multi-cycle ops), carried over a valid/ready handshake.
- Long-latency results are buffered in a small FIFO. A starvation counter raises a pipeline stall request.
- Sits between the CP WB stage / LSU return path and the register file.

Parameters:
- DATA_WIDTH, 32, width of write data.
- RF_INDEX_WIDTH, 5, register index width; the register file has 2**RF_INDEX_WIDTH entries.
- LQ_DEPTH, 4, long-latency queue depth; power of 2, at least 2.
- STARVE_LIMIT, 8, number of consecutive blocked cycles before a stall request.

Ports:
- iClk  in  1  system clock, positive-edge
- iRst  in  1  reset, asynchronous, active-high
- iEX_WB_Write_Enable  in  1  pipeline result valid
- iEX_WB_Write_Addr  in  RF_INDEX_WIDTH  pipeline destination
- iEX_WB_Write_Data  in  DATA_WIDTH  pipeline result
- iLL_WB_Valid  in  1  long-latency result valid
- iLL_WB_Addr  in  RF_INDEX_WIDTH  long-latency destination
- iLL_WB_Data  in  DATA_WIDTH  long-latency result
- oLL_WB_Ready  out  1  long-latency result accepted this cycle
- oWB_RF_Write_Enable  out  1  register-file write enable
- oWB_RF_Write_Addr  out  RF_INDEX_WIDTH  register-file write address
- oWB_RF_Write_Data  out  DATA_WIDTH  register-file write data
- oWB_Stall_Req  out  1  request that the CP pipeline freeze EX for one or more cycles
- oLQ_Count  out  clog2(LQ_DEPTH)+1  queue occupancy

Behaviour:
- **Reset:** one clock (iClk); reset iRst is asynchronous and active-high. On reset:
  - oWB_RF_Write_Enable = 0, oWB_RF_Write_Addr = 0, oWB_RF_Write_Data = 0;
  - oWB_Stall_Req = 0, oLQ_Count = 0;
  - queue pointers cleared and starve counter = 0.
  - Queue contents are discarded if reset arrives mid-operation.
- **Register 0 filtering:**
  - An EX write to address 0 is treated as no EX write, which leaves the port free for the queue.
  - An accepted long-latency result to address 0 is dropped and never enters the queue. oLL_WB_Ready is still asserted for it.
- **EX write definition:** exwr = iEX_WB_Write_Enable AND iEX_WB_Write_Addr != 0.
- **Handshake:**
  - oLL_WB_Ready = (oLQ_Count < LQ_DEPTH). It is combinational from registered state only.
  - Transfer occurs when iLL_WB_Valid AND oLL_WB_Ready.
  - The producer holds valid, address and data stable until the transfer.
- **Port selection** (evaluated each cycle; the selected write is registered onto the outputs, giving 1-cycle latency):
  - If exwr: output the EX write. The queue head is blocked.
  - Else if the queue is non-empty: pop the head and output it.
  - Else if a transfer occurs (with a nonzero address): fall through directly, not enqueued. Latency is 1 cycle.
  - Else: oWB_RF_Write_Enable = 0 next cycle. Address and data hold their previous values.
- **Enqueue:** a transfer that is not taken by the fall-through path is enqueued.
  - A simultaneous push and pop in the same cycle leaves the count unchanged.
  - When full, ready is low, so no push can occur. A pop in that cycle does not reopen ready until the next cycle.
- **Ordering:**
  - FIFO order is preserved among long-latency results.
  - Ordering between the EX and long-latency sources is not enforced here; the CP ID scoreboard prevents overlapping in-flight destinations.
- **Starvation control:**
  - The counter increments each cycle in which exwr is true and the queue is non-empty.
  - It clears on any cycle in which the queue pops or becomes empty.
  - oWB_Stall_Req is registered: it goes to 1 the cycle after the counter reaches STARVE_LIMIT, or the cycle after the queue becomes full.
  - While stalled, the pipeline guarantees iEX_WB_Write_Enable = 0, so the queue drains one entry per cycle.
  - oWB_Stall_Req deasserts the cycle after the queue is empty.
  - The counter saturates at STARVE_LIMIT.
- **Pointers:** wrap modulo LQ_DEPTH. Count is kept explicitly to distinguish full from empty.

Optional Feature:
- Macro: CP_WB_PENDING_EN.
- When defined, an extra output oWB_Pending_Mask (2**RF_INDEX_WIDTH bits) is added.
  - Bit r is 1 while any queued entry targets register r, which allows ID-stage interlock.
  - The mask is registered and updates on the same edge as push and pop. Bit 0 is always 0.
  - Duplicate addresses in the queue are tracked with a per-register count, so a bit clears only when the last entry for that register leaves.
- When not defined, the port and its logic are absent. The remaining behaviour is identical.

Test Plan:
- **Reset mid-drain:** queue holds 3 entries; assert iRst -> all outputs are 0 immediately; after release, oLQ_Count = 0 and no stale write occurs.
- **Fall-through:** queue empty, no EX write; LL write r5 = 0xDEADBEEF -> the next cycle has WE = 1, addr = 5, data = 0xDEADBEEF; oLQ_Count stays 0.
- **Priority:** EX write r3 = 0x11 and LL write r7 = 0x22 in the same cycle -> cycle+1 writes r3 = 0x11; cycle+2 writes r7 = 0x22.
- **r0 filtering:** EX write r0 = 0xFF with queue head r9 = 0x5 -> the next cycle writes r9 = 0x5; a LL write to r0 is accepted with ready = 1, oLQ_Count is unchanged, and no write is generated.
- **Full and stall:**
  - EX writes continuously; 4 LL pushes -> oLL_WB_Ready = 0 and oWB_Stall_Req = 1 on the following cycle.
  - Once EX is idle, the queue drains in FIFO order over 4 consecutive writes; stall drops one cycle after empty.
- **Starvation:** 1 queued entry, EX writes for 8 consecutive cycles -> oWB_Stall_Req rises after the 8th cycle; it clears after the pop drains the queue. With CP_WB_PENDING_EN, the pending mask bit for that register tracks the entry and clears when it pops.
